// File: rtl/xswitch_gen2_if.sv
// xswitch_gen2_if: source/destination/config bundle of the crossbar
//   master: drives addr_in/data_in/wr_en, rd_en, prio_wr/prio_val, arb_mode, port_wr/port_addr/port_en
//   slave : drives data_rcv, addr_out/data_out, data_rdy, fifo_empty/ae/af/full
interface xswitch_gen2_if #(
  parameter int NPORT = 4,
  parameter int DW    = 8
);
  localparam int AW = $clog2(NPORT);
  logic [NPORT*AW-1:0] addr_in;
  logic [NPORT*DW-1:0] data_in;
  logic [NPORT-1:0]    wr_en;
  logic [NPORT-1:0]    data_rcv;
  logic [NPORT*AW-1:0] addr_out;
  logic [NPORT*DW-1:0] data_out;
  logic [NPORT-1:0]    rd_en;
  logic [NPORT-1:0]    data_rdy;
  logic [NPORT-1:0]    fifo_empty;
  logic [NPORT-1:0]    fifo_ae;
  logic [NPORT-1:0]    fifo_af;
  logic [NPORT-1:0]    fifo_full;
  logic                prio_wr;
  logic [NPORT*2-1:0]  prio_val;
  logic                arb_mode;
  logic                port_wr;
  logic [AW-1:0]       port_addr;
  logic                port_en;
  modport master (
    output addr_in, data_in, wr_en, rd_en, prio_wr, prio_val, arb_mode, port_wr, port_addr, port_en,
    input  data_rcv, addr_out, data_out, data_rdy, fifo_empty, fifo_ae, fifo_af, fifo_full
  );
  modport slave (
    input  addr_in, data_in, wr_en, rd_en, prio_wr, prio_val, arb_mode, port_wr, port_addr, port_en,
    output data_rcv, addr_out, data_out, data_rdy, fifo_empty, fifo_ae, fifo_af, fifo_full
  );
endinterface

// File: rtl/xswitch_gen2.sv
// xswitch_gen2: NPORT x NPORT crossbar with per-destination FWFT FIFOs and fixed/round-robin arbitration
//   clk, reset : single clock, synchronous active-high reset
//   bus        : xswitch_gen2_if.slave (source writes, destination reads, priority/enable config, status)
module xswitch_gen2 #(
  parameter int NPORT  = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 8,
  parameter int AE_LVL = 2,
  parameter int AF_LVL = 6
) (
  input logic clk,
  input logic reset,
  xswitch_gen2_if.slave bus
);
  localparam int AW = $clog2(NPORT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW+DW-1:0] r_mem [NPORT][DEPTH];
  logic [PW-1:0]    r_wp  [NPORT];
  logic [PW-1:0]    r_rp  [NPORT];
  logic [CW-1:0]    r_cnt [NPORT];
  logic [AW-1:0]    r_rr  [NPORT];
  logic [1:0]       r_prio[NPORT];
  logic [NPORT-1:0] r_en;
  logic [NPORT-1:0] r_rcv;
  logic [NPORT-1:0] w_fnd;
  logic [NPORT-1:0] w_gnt;
  logic [NPORT-1:0] w_pop;
  logic [NPORT-1:0] w_ack;
  logic [AW-1:0]    w_win [NPORT];
  logic [DW-1:0]    w_dat [NPORT];
  // Scan order starts at rr_ptr in round-robin mode, at source 0 in fixed mode;
  // fixed mode only displaces the current pick on a strictly higher priority, so ties keep the lowest index.
  always_comb begin
    logic [AW-1:0] s;
    logic [1:0] best;
    logic req;
    s = '0;
    best = '0;
    req = 1'b0;
    w_fnd = '0;
    w_gnt = '0;
    w_pop = '0;
    w_ack = '0;
    for (int d = 0; d < NPORT; d++) begin
      w_win[d] = '0;
      best = '0;
      for (int k = 0; k < NPORT; k++) begin
        s = bus.arb_mode ? r_rr[d] + AW'(k) : AW'(k);
        req = bus.wr_en[s] && bus.addr_in[int'(s)*AW +: AW] == AW'(d);
        if (req && (!w_fnd[d] || (!bus.arb_mode && r_prio[s] > best))) begin
          w_fnd[d] = 1'b1;
          w_win[d] = s;
          best = r_prio[s];
        end
      end
      w_dat[d] = bus.data_in[int'(w_win[d])*DW +: DW];
      w_gnt[d] = w_fnd[d] && r_en[d] && r_cnt[d] != CW'(DEPTH);
      w_pop[d] = bus.rd_en[d] && r_cnt[d] != '0;
      if (w_gnt[d]) w_ack[w_win[d]] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPORT; i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
        r_cnt[i] <= '0;
        r_rr[i] <= '0;
        r_prio[i] <= '0;
      end
      r_en <= '1;
      r_rcv <= '0;
    end else begin
      r_rcv <= w_ack;
      for (int i = 0; i < NPORT; i++) begin
        if (w_gnt[i]) r_wp[i] <= r_wp[i] + PW'(1);
        if (w_pop[i]) r_rp[i] <= r_rp[i] + PW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_gnt[i]) - CW'(w_pop[i]);
        if (w_gnt[i] && bus.arb_mode) r_rr[i] <= w_win[i] + AW'(1);
        if (bus.prio_wr) r_prio[i] <= bus.prio_val[2*i +: 2];
      end
      if (bus.port_wr) r_en[bus.port_addr] <= bus.port_en;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++)
      if (w_gnt[i]) r_mem[i][r_wp[i]] <= {w_win[i], w_dat[i]};
  end
  always_comb begin
    bus.addr_out = '0;
    bus.data_out = '0;
    bus.fifo_empty = '0;
    bus.fifo_full = '0;
    bus.fifo_ae = '0;
    bus.fifo_af = '0;
    for (int d = 0; d < NPORT; d++) begin
      bus.fifo_empty[d] = r_cnt[d] == '0;
      bus.fifo_full[d] = r_cnt[d] == CW'(DEPTH);
      bus.fifo_ae[d] = r_cnt[d] <= CW'(AE_LVL);
      bus.fifo_af[d] = r_cnt[d] >= CW'(AF_LVL);
      bus.addr_out[d*AW +: AW] = r_cnt[d] == '0 ? '0 : r_mem[d][r_rp[d]][AW+DW-1:DW];
      bus.data_out[d*DW +: DW] = r_cnt[d] == '0 ? '0 : r_mem[d][r_rp[d]][DW-1:0];
    end
  end
  assign bus.data_rdy = ~bus.fifo_empty;
  assign bus.data_rcv = r_rcv;
endmodule

// File: tb/tb_xswitch_gen2.sv
// tb_xswitch_gen2: directed scoreboard bench for xswitch_gen2
module tb_xswitch_gen2;
  localparam int NPORT = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] sb[$];
  xswitch_gen2_if #(.NPORT(NPORT), .DW(DW)) bus();
  xswitch_gen2 #(.NPORT(NPORT), .DW(DW), .DEPTH(8), .AE_LVL(2), .AF_LVL(6)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_wr(int s, int d, logic [DW-1:0] v);
    bus.wr_en[s] = 1'b1;
    bus.addr_in[s*AW +: AW] = AW'(d);
    bus.data_in[s*DW +: DW] = v;
  endtask
  task automatic expect_w(int s, logic [DW-1:0] v);
    sb.push_back({AW'(s), v});
  endtask
  task automatic pop1(int d);
    logic [AW+DW-1:0] e;
    e = sb.size() > 0 ? sb.pop_front() : 'x;
    chk("rdy", 32'(bus.data_rdy[d]), 1);
    chk("head", {bus.addr_out[d*AW +: AW], bus.data_out[d*DW +: DW]}, 32'(e));
    bus.rd_en[d] = 1'b1;
    step();
    bus.rd_en[d] = 1'b0;
  endtask
  initial begin
    bus.addr_in = '0;
    bus.data_in = '0;
    bus.wr_en = '0;
    bus.rd_en = '0;
    bus.prio_wr = 1'b0;
    bus.prio_val = '0;
    bus.arb_mode = 1'b0;
    bus.port_wr = 1'b0;
    bus.port_addr = '0;
    bus.port_en = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("rst_rcv", 32'(bus.data_rcv), 0);
    chk("rst_rdy", 32'(bus.data_rdy), 0);
    chk("rst_dout", 32'(bus.data_out), 0);
    chk("rst_aout", 32'(bus.addr_out), 0);
    chk("rst_empty", 32'(bus.fifo_empty), 4'hF);
    chk("rst_ae", 32'(bus.fifo_ae), 4'hF);
    chk("rst_af", 32'(bus.fifo_af), 0);
    chk("rst_full", 32'(bus.fifo_full), 0);
    set_wr(0, 2, 8'hA5);
    expect_w(0, 8'hA5);
    step();
    bus.wr_en[0] = 1'b0;
    chk("t2_rcv", 32'(bus.data_rcv), 4'b0001);
    chk("t2_rdy", 32'(bus.data_rdy), 4'b0100);
    chk("t2_dout", 32'(bus.data_out[2*DW +: DW]), 8'hA5);
    chk("t2_aout", 32'(bus.addr_out[2*AW +: AW]), 0);
    pop1(2);
    chk("t2_rcv_pulse", 32'(bus.data_rcv), 0);
    chk("t2_rdy_after", 32'(bus.data_rdy), 0);
    bus.prio_val = {2'd1, 2'd0, 2'd3, 2'd3};
    bus.prio_wr = 1'b1;
    step();
    bus.prio_wr = 1'b0;
    set_wr(0, 0, 8'h10);
    set_wr(1, 0, 8'h11);
    set_wr(3, 0, 8'h13);
    expect_w(0, 8'h10);
    expect_w(1, 8'h11);
    expect_w(3, 8'h13);
    step();
    chk("fp_g0", 32'(bus.data_rcv), 4'b0001);
    bus.wr_en[0] = 1'b0;
    step();
    chk("fp_g1", 32'(bus.data_rcv), 4'b0010);
    bus.wr_en[1] = 1'b0;
    step();
    chk("fp_g3", 32'(bus.data_rcv), 4'b1000);
    bus.wr_en[3] = 1'b0;
    for (int i = 0; i < 3; i++) pop1(0);
    chk("fp_empty", 32'(bus.fifo_empty[0]), 1);
    bus.arb_mode = 1'b1;
    for (int s = 0; s < NPORT; s++) set_wr(s, 1, 8'(8'h20 + s));
    for (int s = 0; s < NPORT; s++) expect_w(s, 8'(8'h20 + s));
    expect_w(0, 8'h20);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", 32'(bus.data_rcv), 32'(1 << (i % NPORT)));
    end
    bus.wr_en = '0;
    for (int i = 0; i < 5; i++) pop1(1);
    bus.arb_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_wr(0, 3, 8'(8'h30 + i));
      expect_w(0, 8'(8'h30 + i));
      step();
      chk("fill_rcv", 32'(bus.data_rcv), 4'b0001);
      chk("fill_ae", 32'(bus.fifo_ae[3]), 32'(i + 1 <= 2));
      chk("fill_af", 32'(bus.fifo_af[3]), 32'(i + 1 >= 6));
      chk("fill_full", 32'(bus.fifo_full[3]), 32'(i + 1 == 8));
    end
    set_wr(0, 3, 8'h38);
    expect_w(0, 8'h38);
    step();
    chk("full_blk_rcv", 32'(bus.data_rcv), 0);
    chk("full_blk_full", 32'(bus.fifo_full[3]), 1);
    step();
    chk("full_blk_rcv2", 32'(bus.data_rcv), 0);
    pop1(3);
    chk("full_pop_rcv", 32'(bus.data_rcv), 0);
    chk("full_pop_full", 32'(bus.fifo_full[3]), 0);
    chk("full_pop_af", 32'(bus.fifo_af[3]), 1);
    step();
    chk("full_late_rcv", 32'(bus.data_rcv), 4'b0001);
    chk("full_late_full", 32'(bus.fifo_full[3]), 1);
    bus.wr_en[0] = 1'b0;
    for (int i = 0; i < 8; i++) pop1(3);
    chk("drain_empty", 32'(bus.fifo_empty[3]), 1);
    bus.rd_en[3] = 1'b1;
    step();
    bus.rd_en[3] = 1'b0;
    chk("underflow_empty", 32'(bus.fifo_empty[3]), 1);
    chk("underflow_ae", 32'(bus.fifo_ae[3]), 1);
    chk("underflow_dout", 32'(bus.data_out[3*DW +: DW]), 0);
    for (int i = 0; i < 3; i++) begin
      set_wr(2, 1, 8'(8'h60 + i));
      expect_w(2, 8'(8'h60 + i));
      step();
      chk("dis_q_rcv", 32'(bus.data_rcv), 4'b0100);
    end
    bus.wr_en[2] = 1'b0;
    bus.port_addr = 2'd1;
    bus.port_en = 1'b0;
    bus.port_wr = 1'b1;
    step();
    bus.port_wr = 1'b0;
    set_wr(2, 1, 8'h70);
    expect_w(2, 8'h70);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_blk_rcv", 32'(bus.data_rcv), 0);
    end
    for (int i = 0; i < 3; i++) pop1(1);
    chk("dis_drain_rcv", 32'(bus.data_rcv), 0);
    chk("dis_drain_empty", 32'(bus.fifo_empty[1]), 1);
    bus.port_en = 1'b1;
    bus.port_wr = 1'b1;
    step();
    bus.port_wr = 1'b0;
    chk("en_same_rcv", 32'(bus.data_rcv), 0);
    step();
    chk("en_next_rcv", 32'(bus.data_rcv), 4'b0100);
    bus.wr_en[2] = 1'b0;
    pop1(1);
    chk("en_empty", 32'(bus.fifo_empty[1]), 1);
    set_wr(1, 0, 8'h77);
    step();
    chk("mid_rcv", 32'(bus.data_rcv), 4'b0010);
    chk("mid_rdy", 32'(bus.data_rdy), 4'b0001);
    reset = 1'b1;
    step();
    chk("mid_rst_rcv", 32'(bus.data_rcv), 0);
    chk("mid_rst_empty", 32'(bus.fifo_empty), 4'hF);
    reset = 1'b0;
    bus.wr_en = '0;
    sb.delete();
    step();
    chk("mid_post_rdy", 32'(bus.data_rdy), 0);
    chk("mid_post_rcv", 32'(bus.data_rcv), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xswitch_gen2.md
# xswitch_gen2

Parametrised next-generation crossbar switch: NPORT source ports route DW-bit words by destination address into NPORT per-destination FIFOs of depth DEPTH, drained by destination-side readers. Adds selectable arbitration (fixed-priority or round-robin), per-source programmable priority, per-destination enable and configurable almost-empty/almost-full thresholds. It is the switching core instantiated under the DUT top wrapper.

## Interface
- NPORT, 4, number of source and destination ports; power of two, >= 2; AW = $clog2(NPORT)
- DW, 8, data word width
- DEPTH, 8, entries per destination FIFO; power of two, >= 4
- AE_LVL, 2, fifo_ae asserted when count <= AE_LVL
- AF_LVL, 6, fifo_af asserted when count >= AF_LVL
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- addr_in  in  NPORT*AW  destination address per source (slice s = source s)
- data_in  in  NPORT*DW  write data per source
- wr_en  in  NPORT  write request per source
- data_rcv  out  NPORT  one-cycle acknowledge of an accepted write
- addr_out  out  NPORT*AW  source id of head word per destination
- data_out  out  NPORT*DW  head word per destination
- rd_en  in  NPORT  pop request per destination
- data_rdy  out  NPORT  destination FIFO non-empty
- fifo_empty, fifo_ae, fifo_af, fifo_full  out  NPORT each  per-destination status
- prio_wr  in  1  load all source priorities from prio_val
- prio_val  in  NPORT*2  2-bit priority per source, 3 = highest
- arb_mode  in  1  0 = fixed priority, 1 = round-robin
- port_wr  in  1  write port_en to destination port_addr
- port_addr  in  AW  destination selected by port_wr
- port_en  in  1  1 = enable, 0 = disable

## Operation
- Per destination d each cycle: requesters = {s : wr_en[s] && addr_in[s] == d}. A grant issues only if d is enabled and count[d] < DEPTH (registered count; a same-cycle pop does not free space for a same-cycle write).
- Fixed mode: highest prio_val wins; ties go to lowest source index.
- Round-robin mode: search starts at rr_ptr[d]; the winner w sets rr_ptr[d] = (w+1) mod NPORT; priorities ignored. Pointer holds when no grant.
- A source targets one destination per cycle, so at most one grant per source.
- Granted write enqueues {s, data_in[s]}. Losing/blocked sources get no data_rcv and must hold wr_en with the same addr/data (no dropping, no buffering on the source side).
- Writes to a disabled destination are never granted; its FIFO stays readable and drains normally.
- Read side first-word-fall-through: data_out/addr_out present the head whenever data_rdy = 1. rd_en && data_rdy pops; rd_en on empty is ignored (no underflow, count unchanged).
- Count: count_next = count + push - pop; width $clog2(DEPTH)+1; pointers wrap mod DEPTH.
- Flags combinational from registered count: empty = (count == 0), full = (count == DEPTH), ae/af per thresholds; data_rdy = !empty.
- prio_wr and port_wr take effect from the next cycle; a same-cycle arbitration uses old values.

## Timing
- Reset (synchronous): all FIFOs empty, pointers 0, rr_ptr 0, priorities 0, all destinations enabled. Outputs: data_rcv 0, data_rdy 0, data_out 0, addr_out 0, fifo_empty 1, fifo_ae 1, fifo_af 0, fifo_full 0.
- Reset mid-operation discards all FIFO contents; a grant in the reset cycle is void and its data_rcv is not asserted.
- Write granted at edge t: data_rcv[s] high during cycle t+1 only; data_rdy[d] high in t+1 if FIFO was empty.
- Pop at edge t: next head (or empty) visible in cycle t+1.
- Simultaneous push and pop on non-full, non-empty FIFO: count unchanged. Push and pop on empty: pop ignored, push stored.
- Throughput: one write per destination per cycle, one read per destination per cycle.

## Test plan
- Reset then idle: all outputs at reset values; fifo_empty = all ones, fifo_ae = all ones.
- Source 0 writes 0xA5 to dest 2 -> data_rcv[0] pulses one cycle later; data_rdy[2] = 1, data_out[2] = 0xA5, addr_out[2] = 0; rd_en[2] -> data_rdy[2] = 0 next cycle.
- Fixed mode, prio = {s3:1, s1:3, s0:3}, sources 0,1,3 all write dest 0 and hold -> order in FIFO 0,1,3.
- Round-robin, all 4 sources hold writes to dest 1 for 4 cycles -> grants 0,1,2,3; fifth write cycle grants 0 again.
- Fill dest 3 with 8 words -> fifo_af at count 6, fifo_full at 8; ninth write not acknowledged; pop + write in same full cycle -> write not granted, count 7, write granted next cycle.
- Disable dest 1 via port_wr with 3 words queued -> new writes never acknowledged, 3 queued words still readable; re-enable -> held write accepted next cycle.
